mp_store_retrieve_mem: RTL and testbench

Synthesizable multi-channel store/retrieve memory model; the parametrised successor of the single-port store/retrieve external memory model used by block-level benches.
- NUM_CH requesters share one array through a round-robin arbiter; each channel has valid/ready request and response handshakes.
- Reads are pipelined with a fixed, parametrisable latency.
- A per-entry written bit flags reads of never-stored addresses.

---
 rtl/mp_store_retrieve_mem.sv | 161 ++++++++++++++++
 tb/tb_mp_store_retrieve_mem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_store_retrieve_mem.sv
// Multi-channel store/retrieve memory: NUM_CH requesters share one array through a
// round-robin arbiter; reads return after a fixed RD_LATENCY with a never-written flag.
module mp_store_retrieve_mem #(
  parameter int                NUM_CH     = 2,
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 16,
  parameter int                RD_LATENCY = 2,
  parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic [NUM_CH-1:0]        req_write_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
  output logic [NUM_CH-1:0]        rsp_valid_o,
  input  logic [NUM_CH-1:0]        rsp_ready_i,
  output logic [NUM_CH*DATA_W-1:0] rsp_data_o,
  output logic [NUM_CH-1:0]        rsp_uninit_o,
  output logic                     busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LAST  = RD_LATENCY - 1;

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] inflight, blocked, eligible, grant_oh;
  logic              gnt_vld, accept;
  logic [CH_W-1:0]   gnt_id;
  int                arb_idx;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              rd_uninit;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  written_q;

  logic              pipe_vld_q    [RD_LATENCY];
  logic [CH_W-1:0]   pipe_ch_q     [RD_LATENCY];
  logic [DATA_W-1:0] pipe_data_q   [RD_LATENCY];
  logic              pipe_uninit_q [RD_LATENCY];

  logic [NUM_CH-1:0] rsp_valid_q;
  logic [NUM_CH-1:0] rsp_uninit_q;
  logic [DATA_W-1:0] rsp_data_q [NUM_CH];

  always_comb begin
    inflight = '0;
    for (int s = 0; s < RD_LATENCY; s++) begin
      if (pipe_vld_q[s]) inflight[pipe_ch_q[s]] = 1'b1;
    end
  end

  // A channel whose response is consumed this cycle may be granted again right away.
  assign blocked  = inflight | (rsp_valid_q & ~rsp_ready_i);
  assign eligible = req_valid_i & ~blocked;

  // Scan from the highest offset down so the first eligible channel at/after the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    arb_idx = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      if (eligible[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = CH_W'(arb_idx);
      end
    end
  end

  assign accept = gnt_vld & rst_n_i;

  always_comb begin
    grant_oh = '0;
    if (accept) grant_oh[gnt_id] = 1'b1;
  end

  assign req_ready_o = grant_oh;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_id == CH_W'(NUM_CH - 1)) ? '0 : gnt_id + CH_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  assign sel_write = req_write_i[gnt_id];
  assign sel_addr  = req_addr_i[int'(gnt_id)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata_i[int'(gnt_id)*DATA_W +: DATA_W];
  assign rd_uninit = ~written_q[sel_addr];
  assign rd_data   = rd_uninit ? INIT_VAL : mem_q[sel_addr];

  always_ff @(posedge clk_i) begin
    if (accept && sel_write) mem_q[sel_addr] <= sel_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                written_q           <= '0;
    else if (accept && sel_write) written_q[sel_addr] <= 1'b1;
  end

  // Read pipeline stage 0 captures the array at acceptance; later stages just delay.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < RD_LATENCY; s++) pipe_vld_q[s] <= 1'b0;
    end else begin
      pipe_vld_q[0] <= accept & ~sel_write;
      for (int s = 1; s < RD_LATENCY; s++) pipe_vld_q[s] <= pipe_vld_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_ch_q[0]     <= gnt_id;
    pipe_data_q[0]   <= rd_data;
    pipe_uninit_q[0] <= rd_uninit;
    for (int s = 1; s < RD_LATENCY; s++) begin
      pipe_ch_q[s]     <= pipe_ch_q[s-1];
      pipe_data_q[s]   <= pipe_data_q[s-1];
      pipe_uninit_q[s] <= pipe_uninit_q[s-1];
    end
  end

  // Response stage: the outstanding-read limit guarantees a slot is free on arrival.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_valid_q  <= '0;
      rsp_uninit_q <= '0;
      for (int c = 0; c < NUM_CH; c++) rsp_data_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rsp_valid_q[c] && rsp_ready_i[c]) rsp_valid_q[c] <= 1'b0;
      end
      if (pipe_vld_q[LAST]) begin
        rsp_valid_q[pipe_ch_q[LAST]]  <= 1'b1;
        rsp_uninit_q[pipe_ch_q[LAST]] <= pipe_uninit_q[LAST];
        rsp_data_q[pipe_ch_q[LAST]]   <= pipe_data_q[LAST];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign rsp_data_o[c*DATA_W +: DATA_W] = rsp_data_q[c];
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_uninit_o = rsp_uninit_q;
  assign busy_o       = (|inflight) | (|rsp_valid_q);

endmodule

// File: tb/tb_mp_store_retrieve_mem.sv
// Bench for mp_store_retrieve_mem: vector table, directed corner sequences and
// randomized traffic checked against a transaction-level memory/arbitration model.
module tb_mp_store_retrieve_mem;
  localparam int          NUM_CH     = 2;
  localparam int          ADDR_W     = 8;
  localparam int          DATA_W     = 16;
  localparam int          RD_LATENCY = 2;
  localparam logic [15:0] INIT_VAL   = 16'hDEAD;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        req_valid, req_ready, req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        rsp_valid, rsp_ready, rsp_uninit;
  logic [NUM_CH*DATA_W-1:0] rsp_data;
  logic                     busy;

  always #5 clk = ~clk;

  mp_store_retrieve_mem #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LATENCY(RD_LATENCY), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_uninit_o(rsp_uninit), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: array + written flags, one pending read per channel
  // with the edge number at which its response must appear.
  logic [15:0]       m_mem [256];
  bit                m_wr  [256];
  bit                pend    [NUM_CH];
  int                due     [NUM_CH];
  logic [15:0]       pdata   [NUM_CH];
  bit                puninit [NUM_CH];
  int                mptr = 0;
  int                ecnt = 0;
  logic [NUM_CH-1:0] last_rdy = '0;

  task automatic step();
    logic [NUM_CH-1:0] er;
    bit                shown [NUM_CH];
    int                g, idx, a;
    logic              ebusy;
    @(negedge clk);
    er = '0;
    g  = -1;
    for (int c = 0; c < NUM_CH; c++) shown[c] = pend[c] && (ecnt >= due[c]);
    if (rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (mptr + k) % NUM_CH;
        if (g < 0 && req_valid[idx] && !(pend[idx] && !(shown[idx] && rsp_ready[idx]))) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    last_rdy = req_ready;
    check("model_req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    ecnt++;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
      for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
      mptr = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) if (shown[c] && rsp_ready[c]) pend[c] = 1'b0;
      if (g >= 0) begin
        a = int'(req_addr[g*ADDR_W +: ADDR_W]);
        if (req_write[g]) begin
          m_mem[a] = req_wdata[g*DATA_W +: DATA_W];
          m_wr[a]  = 1'b1;
        end else begin
          pend[g]    = 1'b1;
          due[g]     = ecnt + RD_LATENCY;
          pdata[g]   = m_wr[a] ? m_mem[a] : INIT_VAL;
          puninit[g] = !m_wr[a];
        end
        mptr = (g + 1) % NUM_CH;
      end
    end
    #1;
    ebusy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      ebusy |= pend[c];
      check($sformatf("model_rsp_valid%0d", c), 32'(rsp_valid[c]), 32'(pend[c] && ecnt >= due[c]));
      if (pend[c] && ecnt >= due[c]) begin
        check($sformatf("model_rsp_data%0d", c), 32'(rsp_data[c*DATA_W +: DATA_W]), 32'(pdata[c]));
        check($sformatf("model_rsp_uninit%0d", c), 32'(rsp_uninit[c]), 32'(puninit[c]));
      end
    end
    check("model_busy", 32'(busy), 32'(ebusy));
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct packed {
    logic [1:0]  vld;
    logic [1:0]  wr;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
    logic [1:0]  e_un;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Single channel, uninitialised read, cross-channel store/retrieve (rsp_ready held high).
    tbl[0]  = '{2'b01, 2'b01, 8'd100, 8'd0, 16'd1024, 16'd0,    2'b01, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[1]  = '{2'b01, 2'b00, 8'd100, 8'd0, 16'd0,    16'd0,    2'b01, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[2]  = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[3]  = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b01, 16'd1024, 16'd0,      2'b00};
    tbl[4]  = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[5]  = '{2'b10, 2'b00, 8'd0,   8'd7, 16'd0,    16'd0,    2'b10, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[6]  = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[7]  = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b10, 16'd0,    16'hDEAD,   2'b10};
    tbl[8]  = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[9]  = '{2'b10, 2'b10, 8'd0,   8'd7, 16'd0,    16'd5,    2'b10, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[10] = '{2'b10, 2'b00, 8'd0,   8'd7, 16'd0,    16'd0,    2'b10, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[11] = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[12] = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b10, 16'd0,    16'd5,      2'b00};
    tbl[13] = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[14] = '{2'b11, 2'b01, 8'd3,   8'd3, 16'h1234, 16'd0,    2'b01, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[15] = '{2'b10, 2'b00, 8'd0,   8'd3, 16'd0,    16'd0,    2'b10, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[16] = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};
    tbl[17] = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b10, 16'd0,    16'h1234,   2'b00};
    tbl[18] = '{2'b00, 2'b00, 8'd0,   8'd0, 16'd0,    16'd0,    2'b00, 2'b00, 16'd0,    16'd0,      2'b00};

    for (int c = 0; c < NUM_CH; c++) begin
      pend[c] = 1'b0;
      due[c]  = 0;
    end
    for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '1;
    step();
    step();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_uninit", 32'(rsp_uninit), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      req_valid = tbl[i].vld;
      req_write = tbl[i].wr;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_wdata = {tbl[i].d1, tbl[i].d0};
      rsp_ready = 2'b11;
      step();
      check($sformatf("tbl%0d_ready", i), 32'(last_rdy), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv[0]) begin
        check($sformatf("tbl%0d_data0", i), 32'(rsp_data[15:0]), 32'(tbl[i].e_d0));
        check($sformatf("tbl%0d_uninit0", i), 32'(rsp_uninit[0]), 32'(tbl[i].e_un[0]));
      end
      if (tbl[i].e_rv[1]) begin
        check($sformatf("tbl%0d_data1", i), 32'(rsp_data[31:16]), 32'(tbl[i].e_d1));
        check($sformatf("tbl%0d_uninit1", i), 32'(rsp_uninit[1]), 32'(tbl[i].e_un[1]));
      end
    end

    // Round-robin: both channels store every cycle; pointer is 0 here.
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {8'd40, 8'd20}; req_wdata = {16'h4040, 16'h2020};
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr_grant%0d", k), 32'(last_rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle(2);

    // Backpressure on ch0 while ch1 keeps storing.
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_write = 2'b00; req_addr = {8'd0, 8'd100};
    step();
    check("bp_accept", 32'(last_rdy), 32'd1);
    req_valid = 2'b11; req_write = 2'b10; req_addr = {8'd60, 8'd3}; req_wdata = {16'h0600, 16'd0};
    step();
    check("bp_inflight_ready", 32'(last_rdy), 32'd2);
    step();
    check("bp_rsp_arrive", 32'(rsp_valid[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      req_wdata[31:16] = 16'(16'h0600 + k);
      step();
      check($sformatf("bp_hold_ready%0d", k), 32'(last_rdy), 32'd2);
      check($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp_hold_data%0d", k), 32'(rsp_data[15:0]), 32'd1024);
    end
    rsp_ready = 2'b01;
    step();
    check("bp_consume_grant", 32'(last_rdy), 32'd1);
    check("bp_valid_drop", 32'(rsp_valid[0]), 32'd0);
    idle(4);

    // Reset while a retrieve is in flight.
    req_valid = 2'b01; req_write = 2'b00; req_addr = {8'd0, 8'd100};
    step();
    check("rst_accept", 32'(last_rdy), 32'd1);
    req_addr = {8'd0, 8'd3};
    rst_n = 1'b0;
    step();
    check("rst_ready_forced", 32'(last_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rst_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b01; req_addr = {8'd0, 8'd100};
    step();
    req_valid = '0;
    step();
    step();
    check("rst_after_valid", 32'(rsp_valid[0]), 32'd1);
    check("rst_after_data", 32'(rsp_data[15:0]), 32'hDEAD);
    check("rst_after_uninit", 32'(rsp_uninit[0]), 32'd1);
    idle(2);

    // Randomized traffic; requests stay stable until accepted.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!req_valid[c] || last_rdy[c]) begin
          req_valid[c] = ($urandom_range(0, 9) < 6);
          req_write[c] = $urandom_range(0, 1) == 1;
          req_addr[c*ADDR_W +: ADDR_W]  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 7))
                                                                       : 8'($urandom_range(0, 255));
          req_wdata[c*DATA_W +: DATA_W] = 16'($urandom);
        end
        rsp_ready[c] = ($urandom_range(0, 2) != 0);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
